// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns and digit strobes shared by the display driver and seg_capture.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] SEL_H1 = 4'b0111;
    localparam logic [3:0] SEL_H0 = 4'b1011;
    localparam logic [3:0] SEL_M1 = 4'b1101;
    localparam logic [3:0] SEL_M0 = 4'b1110;

    // One-hot digit select (bit3=h1 .. bit0=m0); zero for any idle strobe value.
    function automatic logic [3:0] strobe_onehot(input logic [3:0] ctr);
        return (ctr inside {SEL_H1, SEL_H0, SEL_M1, SEL_M0}) ? ~ctr : 4'd0;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low a..g segment pattern back to BCD, with a valid flag.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       valid_o
);

    always_comb begin
        bcd_o   = 4'd0;
        valid_o = 1'b1;
        case (seg_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: debounces the multiplexed 7-segment bus, decodes digits and reassembles HH:MM frames.
module seg_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] q,
    input  logic [3:0] ctr,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       stale
);

    localparam int              TW      = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]      ACC_AT  = 8'(STABLE_CNT - 2);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [6:0]    prev_seg_q;
    logic [3:0]    prev_ctr_q;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    seen_q, seen_d, sel;
    logic [3:0]    shadow_q [4];
    logic [3:0]    out_q [4];
    logic          bad_q, seg_err_q, frame_valid_q, stale_q;
    logic [3:0]    bcd;
    logic          bcd_ok, match, acc, acc_ok, done, timeout;

    seg7_decode u_dec (.seg_i(q), .bcd_o(bcd), .valid_o(bcd_ok));

    // cnt_q counts repeats of the sampled pair, so the pair has been seen cnt_q+1 times.
    always_comb begin
        sel     = strobe_onehot(ctr);
        match   = {ctr, q} == {prev_ctr_q, prev_seg_q};
        cnt_d   = (sel == 4'd0 || !match) ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        acc     = sel != 4'd0 && match && cnt_q == ACC_AT;
        acc_ok  = acc && bcd_ok;
        done    = &seen_q;
        timeout = to_q == TO_LAST && !acc_ok;
        seen_d  = ((done || timeout) ? 4'd0 : seen_q) | (acc_ok ? sel : 4'd0);
        to_d    = (done || acc_ok || timeout) ? '0 : to_q + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_seg_q    <= '0;
            prev_ctr_q    <= '0;
            cnt_q         <= '0;
            to_q          <= '0;
            seen_q        <= '0;
            bad_q         <= 1'b0;
            seg_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            stale_q       <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            prev_seg_q    <= q;
            prev_ctr_q    <= ctr;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            seen_q        <= seen_d;
            bad_q         <= acc && !bcd_ok;
            seg_err_q     <= bad_q;
            frame_valid_q <= done;
            stale_q       <= done ? 1'b0 : timeout ? 1'b1 : stale_q;
            for (int i = 0; i < 4; i++) begin
                if (acc_ok && sel[i]) shadow_q[i] <= bcd;
                if (done) out_q[i] <= shadow_q[i];
            end
        end
    end

    assign h1          = out_q[3];
    assign h0          = out_q[2];
    assign m1          = out_q[1];
    assign m0          = out_q[0];
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed and random bus traffic against a dwell-length reference model.
module tb_seg_capture;

    localparam int S = 4;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] q = '0;
    logic [3:0] ctr = 4'hF;
    logic [3:0] h1, h0, m1, m0;
    logic       frame_valid, seg_err, stale;

    int n_chk = 0;
    int n_pass = 0;

    logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [3:0] sels [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Model state: digits indexed 0=h1 .. 3=m0; run is the length of the current dwell in edges.
    int          run, since;
    logic [10:0] last;
    logic [3:0]  seen;
    logic [3:0]  shadow [4];
    logic [15:0] m_time;
    logic        m_fv, m_err, m_stale, err_pend;

    seg_capture #(.STABLE_CNT(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .q(q), .ctr(ctr),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0),
        .frame_valid(frame_valid), .seg_err(seg_err), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int dig_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (sels[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        run = 0; since = 0; last = '0; seen = '0;
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        m_time = '0; m_fv = 0; m_err = 0; m_stale = 1; err_pend = 0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic [6:0] p);
        int d, v;
        logic fv, tmo, acc, ok;
        d = dig_of(c);
        v = -1;
        for (int i = 0; i < 10; i++) if (pat[i] == p) v = i;
        fv = (seen == 4'hF);
        tmo = (since == T - 1);
        m_fv = fv;
        m_err = err_pend;
        if (fv) begin
            m_time = {shadow[0], shadow[1], shadow[2], shadow[3]};
            m_stale = 0;
        end
        if (d < 0) run = 0;
        else if ({c, p} == last) run++;
        else run = 1;
        last = {c, p};
        acc = (d >= 0) && (run == S);
        ok = acc && (v >= 0);
        err_pend = acc && (v < 0);
        tmo = tmo && !ok;
        if (fv || tmo) seen = '0;
        if (tmo && !fv) m_stale = 1;
        if (ok) begin
            seen[d] = 1'b1;
            shadow[d] = 4'(v);
        end
        since = (fv || ok || tmo) ? 0 : since + 1;
    endtask

    task automatic check_outputs();
        check("hhmm", {16'd0, h1, h0, m1, m0}, {16'd0, m_time});
        check("frame_valid", frame_valid, m_fv);
        check("seg_err", seg_err, m_err);
        check("stale", stale, m_stale);
    endtask

    task automatic cycle(input logic [3:0] c, input logic [6:0] p);
        ctr = c;
        q = p;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(c, p);
        #1;
        check_outputs();
    endtask

    task automatic dwell(input logic [3:0] c, input logic [6:0] p, input int n);
        repeat (n) cycle(c, p);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        dwell(sels[0], pat[a], 6);
        dwell(sels[1], pat[b], 6);
        dwell(sels[2], pat[c], 6);
        dwell(sels[3], pat[d], 6);
        dwell(4'hF, 7'h7F, 2);
    endtask

    initial begin
        int k, len;
        logic [3:0] c;
        logic [6:0] p;
        model_reset();
        repeat (3) cycle(4'($urandom), 7'($urandom));
        check("reset_stale", stale, 1);
        reset = 1'b1;

        frame(2, 3, 4, 5);
        check("frame_2345", {h1, h0, m1, m0}, 16'h2345);
        check("frame_stale", stale, 0);

        dwell(sels[0], pat[1], 3);
        dwell(sels[1], pat[2], 6);
        dwell(sels[2], pat[3], 6);
        dwell(sels[3], pat[4], 6);
        dwell(4'hF, 7'h7F, 2);
        check("glitch_hold", {h1, h0, m1, m0}, 16'h2345);
        dwell(sels[0], pat[1], 6);
        dwell(4'hF, 7'h7F, 2);
        check("glitch_recover", {h1, h0, m1, m0}, 16'h1234);

        dwell(sels[2], 7'h7F, 6);
        dwell(sels[0], pat[1], 6);
        dwell(sels[1], pat[7], 6);
        dwell(sels[3], pat[8], 6);
        dwell(4'hF, 7'h7F, 2);
        check("bad_seg_hold", {h1, h0, m1, m0}, 16'h1234);
        dwell(sels[2], pat[3], 6);
        dwell(4'hF, 7'h7F, 2);
        check("bad_seg_recover", {h1, h0, m1, m0}, 16'h1738);

        frame(1, 2, 3, 4);
        dwell(sels[0], pat[9], 6);
        dwell(4'hF, 7'h7F, 40);
        check("timeout_stale", stale, 1);
        check("timeout_hold", {h1, h0, m1, m0}, 16'h1234);
        frame(0, 9, 5, 9);
        check("after_timeout", {h1, h0, m1, m0}, 16'h0959);
        check("after_timeout_stale", stale, 0);

        dwell(sels[0], pat[2], 6);
        dwell(sels[1], pat[1], 6);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_clear", {h1, h0, m1, m0}, 16'h0000);
        check("async_stale", stale, 1);
        dwell(sels[1], pat[1], 2);
        reset = 1'b1;
        dwell(sels[2], pat[3], 6);
        dwell(sels[3], pat[4], 6);
        dwell(4'hF, 7'h7F, 3);
        check("partial_discarded", {h1, h0, m1, m0}, 16'h0000);

        repeat (400) begin
            k = $urandom_range(0, 9);
            c = (k < 6 || k == 9) ? sels[k % 4] : (k == 6) ? 4'hF : (k == 7) ? 4'h0 : 4'($urandom);
            p = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)];
            len = $urandom_range(1, 8);
            dwell(c, p, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receiving end of the multiplexed 4-digit 7-segment bus (segment lines q, digit strobes ctr) that the clock's display driver produces.
- Samples the bus, debounces each digit dwell, and decodes segment patterns back to BCD.
- Reassembles the full HH:MM frame (h1,h0,m1,m0) and flags bad patterns and a stalled bus.
- Used as a loopback/self-check monitor and as the input stage of a slave display board.

Parameters:
- STABLE_CNT, 4: consecutive identical (ctr,q) samples required to accept a digit; legal range 2..255.
- TIMEOUT_CYC, 65535: clk cycles with no accepted digit before the frame is declared stale; minimum 16.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- q  in  7  segment lines, active-low, q[6]=a .. q[0]=g.
- ctr  in  4  digit strobes, active-low, one-hot-low.
- h1  out  4  hours tens, BCD.
- h0  out  4  hours units, BCD.
- m1  out  4  minutes tens, BCD.
- m0  out  4  minutes units, BCD.
- frame_valid  out  1  one-cycle pulse when h1/h0/m1/m0 update.
- seg_err  out  1  one-cycle pulse when a stable digit carries an undecodable pattern.
- stale  out  1  level; high when no complete frame has been received since reset or timeout.

Behaviour:
- Reset (async, reset=0):
  - h1/h0/m1/m0 = 0; frame_valid = 0; seg_err = 0; stale = 1.
  - Seen bits, shadow registers, stability counter, timeout counter and sample registers all cleared.
  - Reset mid-frame discards any partial frame.
- Strobe decode:
  - 4'b0111 selects h1; 4'b1011 selects h0; 4'b1101 selects m1; 4'b1110 selects m0.
  - Any other value (4'b0000, 4'b1111, multiple lows) is idle: no acceptance, stability counter held at 0.
- Segment decode, combinational:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - Any other pattern is invalid.
- Stability:
  - Inputs are registered each edge into prev_q/prev_ctr.
  - cnt resets to 0 when (ctr,q) differs from (prev_ctr,prev_q) or ctr is idle; otherwise cnt increments, saturating at 255.
  - A digit is accepted on the edge where cnt reaches STABLE_CNT-1, i.e. the pair has been present at STABLE_CNT consecutive edges.
  - Exactly one acceptance per dwell; no re-acceptance until the pair changes.
- On acceptance with a valid pattern:
  - Shadow register for the strobed digit is loaded and its seen bit set.
  - Timeout counter clears.
  - Repeating a digit before the frame completes overwrites its shadow; the seen bit stays set.
- On acceptance with an invalid pattern:
  - seg_err pulses for 1 cycle on the following edge.
  - Shadow and seen bits are unchanged; timeout counter is not cleared.
- Frame completion:
  - On the edge after all four seen bits are set, shadows are copied to h1/h0/m1/m0.
  - frame_valid pulses for 1 cycle, seen bits clear, and stale goes 0.
  - Latency from the accepting edge of the fourth digit to outputs: 1 clk.
  - Outputs hold their values between frames.
- Timeout:
  - The counter increments every cycle without a valid acceptance.
  - When it reaches TIMEOUT_CYC-1: seen bits clear, stale goes 1, counter resets.
  - h1..m0 retain their last values.
  - If frame completion and timeout occur in the same cycle, completion wins and the counter clears.
- No arithmetic beyond the counters; counter widths are $clog2 of their limits.
- Input synchronisation is not in this block: q and ctr are required synchronous to clk.

Decomposition:
- Shared package seg7_pkg:
  - SEG_0..SEG_9 seven-bit constants (active-low, a..g order).
  - SEL_H1/SEL_H0/SEL_M1/SEL_M0 strobe constants.
  - Shared with the display driver so encode and decode tables cannot diverge.
- One sub-module, seg7_decode: combinational, 7-bit pattern in; 4-bit BCD plus valid out.

Test Plan:
- Reset and wait 3 cycles → h1..m0=0, frame_valid=0, seg_err=0, stale=1; any input activity during reset has no effect.
- STABLE_CNT=4; drive ctr=0111/q=0010010 (2), 1011/0000110 (3), 1101/1001100 (4), 1110/0100100 (5), each held 6 cycles → single frame_valid pulse 1 cycle after the m0 acceptance; h1=2, h0=3, m1=4, m0=5; stale=0.
- Hold a digit only 3 cycles (glitch) then proceed with the other three digits → that digit is not accepted and no frame_valid appears; after a proper 6-cycle dwell of the missing digit → frame_valid asserts.
- ctr=1101 with q=1111111 held 6 cycles → exactly one seg_err pulse; m1 seen bit not set; no frame_valid after the other three digits until a valid m1 arrives.
- TIMEOUT_CYC=32; complete one frame (1,2,3,4), then send only h1 and go idle (ctr=1111) 40 cycles → stale=1 at cycle 32 after the h1 acceptance; outputs still 1,2,3,4; next full frame (0,9,5,9) → stale=0, outputs 0,9,5,9.
- Assert reset in the middle of a frame after h1 and h0 are accepted → outputs 0, stale=1; subsequent m1 and m0 alone do not produce frame_valid.
